// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial add sequencer.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Bit-counter width; never narrower than one bit so WIDTH=1 still has a counter.
    function automatic int unsigned CNT_W(input int unsigned width);
        int unsigned w;
        w = (width <= 32'd1) ? 32'd1 : 32'($clog2(width));
        return w;
    endfunction

endpackage

// File: rtl/half_adder.sv
// Half_Adder cell shared with the parallel adder library.
module Half_Adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_add_ctrl_bit_full_adder.sv
// One-bit full adder built from two Half_Adder cells and an OR of their carries.
module bit_full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic s1;
    logic c1;
    logic c2;

    Half_Adder u_ha1 (
        .a (x),
        .b (y),
        .s (s1),
        .c (c1)
    );

    Half_Adder u_ha2 (
        .a (s1),
        .b (ci),
        .s (s),
        .c (c2)
    );

    assign co = c1 | c2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add sequencer: accepts a/b/cin, adds one bit per cycle on a single
// full-adder cell, and returns sum/cout over a valid/ready handshake.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned     CW   = CNT_W(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] sh_s;
    logic [WIDTH-1:0] sh_s_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             bit_s;
    logic             bit_co;
    logic             accept;
    logic             last_bit;

    bit_full_adder u_fa (
        .x  (sh_a[0]),
        .y  (sh_b[0]),
        .ci (carry),
        .s  (bit_s),
        .co (bit_co)
    );

    assign accept    = in_valid && (state == IDLE);
    assign last_bit  = (cnt == LAST);
    // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    assign sh_s_next = (sh_s >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept)    state_next = RUN;
            RUN:     if (last_bit)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Operand/sum shift registers, carry, bit counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_a  <= '0;
            sh_b  <= '0;
            sh_s  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        sh_a  <= a;
                        sh_b  <= b;
                        sh_s  <= '0;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    sh_s  <= sh_s_next;
                    carry <= bit_co;
                    cnt   <= cnt + CW'(1);
                    if (last_bit) begin
                        sum  <= sh_s_next;
                        cout <= bit_co;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: directed + streaming at WIDTH=8,
// plus streaming-only instances at WIDTH=1 and WIDTH=16.
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         rst_aux;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int           tests = 0;
    int           fails = 0;
    int           cyc = 0;
    logic [W:0]   exp_q[$];
    int           acc_cyc = 0;
    int           last_acc = 0;
    int           acc_n = 0;
    bit           stream = 1'b0;
    logic         prev_ov = 1'b0;
    bit           aux_done[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    serial_add_ctrl #(.WIDTH(W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic report_fail(input string name, input string msg);
        tests++;
        fails++;
        $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    // Monitor: records accepts into the scoreboard and checks each delivered result.
    always @(negedge clk) begin
        logic [W:0] e;
        if (rst) begin
            exp_q.delete();
            prev_ov = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_add(a, b, cin));
                if (stream && acc_n > 0) check("w8_spacing", 32'(cyc - last_acc), W + 2);
                last_acc = cyc;
                acc_cyc  = cyc;
                acc_n++;
            end
            if (out_valid && !prev_ov) check("w8_latency", 32'(cyc - acc_cyc), W + 1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    report_fail("w8_unexpected_out", "out_valid with no pending operation");
                end else begin
                    e = exp_q.pop_front();
                    check("w8_sum", 32'(sum), 32'(e[W-1:0]));
                    check("w8_cout", 32'(cout), 32'(e[W]));
                end
            end
            prev_ov = out_valid;
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready && !out_valid && exp_q.size() == 0) return;
        end
        report_fail("w8_wait_idle", "timed out waiting for IDLE");
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        wait_idle();
        @(posedge clk); #1;
        in_valid = 1'b1; a = x; b = y; cin = c;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_idle();
    endtask

    initial begin
        int  bcnt;
        bit  ov_seen;
        bit  will;
        bit  done_ok;

        rst = 1'b1; rst_aux = 1'b1;
        in_valid = 1'b1; a = 8'hA5; b = 8'h5A; cin = 1'b1; out_ready = 1'b1;

        // Reset with in_valid asserted: nothing accepted, outputs at reset values.
        repeat (2) begin
            @(negedge clk);
            check("rst_in_ready", 32'(in_ready), 1);
            check("rst_out_valid", 32'(out_valid), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_sum", 32'(sum), 0);
            check("rst_cout", 32'(cout), 0);
        end
        @(posedge clk); #1;
        rst = 1'b0; rst_aux = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_no_accept", 32'(exp_q.size()), 0);

        // Basic add with busy-length measurement.
        wait_idle();
        @(posedge clk); #1;
        in_valid = 1'b1; a = 8'h3C; b = 8'h05; cin = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        bcnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
            else if (bcnt > 0) break;
        end
        check("w8_busy_cycles", 32'(bcnt), W + 1);
        check("w8_basic_sum", 32'(sum), 32'h41);

        // Carry chain.
        run_op(8'hFF, 8'h01, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1);
        run_op(8'h00, 8'h00, 1'b1);

        // Backpressure in DONE with new operands offered.
        wait_idle();
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        if (!out_valid) report_fail("bp_wait_done", "out_valid never rose");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid = (i % 2 == 0);
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_sum_stable", 32'(sum), 32'h46);
            check("bp_in_ready", 32'(in_ready), 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_idle_in_ready", 32'(in_ready), 1);
        check("bp_idle_out_valid", 32'(out_valid), 0);
        check("bp_sum_held", 32'(sum), 32'h46);

        // Abort with reset during the third RUN cycle.
        wait_idle();
        @(posedge clk); #1;
        in_valid = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", 32'(in_ready), 1);
        check("abort_busy", 32'(busy), 0);
        check("abort_sum_cleared", 32'(sum), 0);
        ov_seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) ov_seen = 1'b1;
        end
        check("abort_no_out_valid", 32'(ov_seen), 0);
        run_op(8'h01, 8'h01, 1'b0);
        check("after_abort_sum", 32'(sum), 32'h02);

        // Streaming with in_valid and out_ready held high.
        wait_idle();
        @(posedge clk); #1;
        stream = 1'b1; acc_n = 0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        in_valid = 1'b1;
        done_ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            will = in_ready;
            @(posedge clk); #1;
            if (will) begin
                if (acc_n >= 200) begin
                    done_ok = 1'b1;
                    break;
                end
                a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            end
        end
        in_valid = 1'b0;
        if (!done_ok) report_fail("w8_stream", "stream did not complete");
        wait_idle();
        stream = 1'b0;
        check("w8_stream_count", 32'(acc_n), 200);

        done_ok = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (aux_done[0] && aux_done[1]) begin
                done_ok = 1'b1;
                break;
            end
        end
        if (!done_ok) report_fail("aux_streams", "auxiliary widths did not finish");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Streaming-only instances at other widths.
    for (genvar g = 0; g < 2; g++) begin : g_aux
        localparam int unsigned AW = (g == 0) ? 1 : 16;

        logic [AW-1:0] xa;
        logic [AW-1:0] xb;
        logic [AW-1:0] xs;
        logic          xci;
        logic          xiv;
        logic          xir;
        logic          xov;
        logic          xco;
        logic          xbusy;
        logic [AW:0]   xq[$];
        int            xn = 0;
        int            xlast = 0;

        serial_add_ctrl #(.WIDTH(AW)) u_dut (
            .clk       (clk),
            .rst       (rst_aux),
            .in_valid  (xiv),
            .in_ready  (xir),
            .a         (xa),
            .b         (xb),
            .cin       (xci),
            .out_valid (xov),
            .out_ready (1'b1),
            .sum       (xs),
            .cout      (xco),
            .busy      (xbusy)
        );

        always @(negedge clk) begin
            logic [AW:0] xe;
            if (rst_aux === 1'b0) begin
                if (xiv && xir) begin
                    xq.push_back({1'b0, xa} + {1'b0, xb} + {{AW{1'b0}}, xci});
                    if (xn > 0) check($sformatf("w%0d_spacing", AW), 32'(cyc - xlast), AW + 2);
                    xlast = cyc;
                    xn++;
                end
                if (xov) begin
                    if (xq.size() == 0) begin
                        report_fail($sformatf("w%0d_unexpected_out", AW), "no pending operation");
                    end else begin
                        xe = xq.pop_front();
                        check($sformatf("w%0d_sum", AW), 32'(xs), 32'(xe[AW-1:0]));
                        check($sformatf("w%0d_cout", AW), 32'(xco), 32'(xe[AW]));
                    end
                end
            end
        end

        initial begin
            bit will;
            bit ok;
            xiv = 1'b0; xa = '0; xb = '0; xci = 1'b0;
            aux_done[g] = 1'b0;
            repeat (4) @(posedge clk);
            wait (rst_aux === 1'b0);
            #1;
            xa = AW'($urandom); xb = AW'($urandom); xci = 1'($urandom);
            xiv = 1'b1;
            ok = 1'b0;
            for (int i = 0; i < 10000; i++) begin
                @(negedge clk);
                will = xir;
                @(posedge clk); #1;
                if (will) begin
                    if (xn >= 200) begin
                        ok = 1'b1;
                        break;
                    end
                    xa = AW'($urandom); xb = AW'($urandom); xci = 1'($urandom);
                end
            end
            xiv = 1'b0;
            if (!ok) report_fail($sformatf("w%0d_stream", AW), "stream did not complete");
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (xq.size() == 0 && xir) break;
            end
            check($sformatf("w%0d_drained", AW), 32'(xq.size()), 0);
            check($sformatf("w%0d_count", AW), 32'(xn), 200);
            aux_done[g] = 1'b1;
        end
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial add sequencer. It accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake, then adds them one bit per cycle on a single full-adder cell built from two Half_Adder instances. It returns sum and carry-out over a second valid/ready handshake. It is the area-minimal alternative to the parallel carry lookahead adder, and shares the same Half_Adder cell library.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range WIDTH >= 1.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands and cin are valid
in_ready  output  1  block can accept operands; high only in IDLE
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in
out_valid  output  1  sum/cout are valid; high only in DONE
out_ready  input  1  consumer accepts the result
sum  output  WIDTH  registered result, a+b+cin modulo 2^WIDTH
cout  output  1  registered carry-out of bit WIDTH-1
busy  output  1  high in RUN or DONE

Behaviour:
- One clock and one reset. Reset is synchronous and active-high: rst is sampled on the rising edge of clk and has priority over all other inputs.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0. Shift registers, carry register and bit counter are cleared to 0.
- FSM with states IDLE, RUN, DONE.
- IDLE to RUN: on an edge where in_valid && in_ready.
  - Load a into shift register A and b into shift register B.
  - Load cin into the carry register and set the bit counter to 0.
- RUN, on every edge:
  - Cell inputs are A[0], B[0] and carry.
  - HA1(A[0],B[0]) produces c1 and s1. HA2(s1,carry) produces c2 and the bit sum s. The new carry is c1|c2.
  - A and B shift right by 1. The sum shift register shifts right and s enters at the MSB.
  - The counter increments.
  - When the counter equals WIDTH-1 on this edge, the state moves to DONE. On that same edge, the final sum shift value loads into sum and the new carry loads into cout.
- RUN therefore lasts exactly WIDTH cycles. out_valid is first high WIDTH edges after the accepting edge.
- DONE: out_valid=1. sum and cout hold stable while out_ready=0. On an edge with out_ready=1 the state moves to IDLE.
- in_ready is combinational: (state==IDLE). in_valid is ignored outside IDLE. No input is registered unless it is accepted.
- sum and cout change only on the DONE-entry edge and on reset. Between operations they hold the last result.
- Throughput: out_ready is not combined with in_ready in the same cycle. The earliest next accept is the cycle after the DONE to IDLE edge, which gives at most one op per WIDTH+2 cycles.
- Reset mid-RUN or mid-DONE: the operation is aborted. The next cycle is IDLE with out_valid=0, and the partial result is discarded.
- Counter width is max(1,$clog2(WIDTH)). With WIDTH=1, RUN lasts one cycle.
- Overflow semantics: unsigned. cout carries the overflow and no saturation is applied.

Decomposition:
- Package serial_add_pkg:
  - state typedef: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - Function CNT_W(width) returning max(1,$clog2(width)).
- Sub-module bit_full_adder: inputs x, y, ci; outputs s, co. It contains two Half_Adder instances and the OR of their carries. serial_add_ctrl instantiates it once.

Test Plan:
1. Reset behaviour: hold rst 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, busy=0, sum=0x00, cout=0; nothing is accepted during rst.
2. Basic add, WIDTH=8: a=0x3C, b=0x05, cin=0 -> out_valid rises exactly 8 edges after accept; sum=0x41, cout=0; busy high for 9 cycles with out_ready=1.
3. Carry chain: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1. Then a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
4. Backpressure: a=0x12, b=0x34, out_ready=0 for 5 cycles in DONE, with in_valid pulsed and new operands -> out_valid held, sum=0x46 stable, in_ready=0, new operands ignored. Then out_ready=1 -> IDLE next cycle.
5. Abort: rst asserted on the 3rd RUN cycle of a=0xAA, b=0x55 -> IDLE next cycle, out_valid never asserted. A following op a=0x01, b=0x01 -> sum=0x02.
6. Streaming: in_valid and out_ready held high, random operands for 200 ops -> accepts spaced exactly 10 cycles apart; every sum/cout matches the reference model (a+b+cin). Repeat with WIDTH=1 and WIDTH=16.
